// File: rtl/miner_work_scheduler.sv
// rtl/miner_work_scheduler.sv - work sequencer and golden-nonce collector for the SHA-256 miner core
// Optional build macro: MINER_SCHED_STATS_EN (adds stat_found / stat_dropped counters)
module miner_work_scheduler #(
  parameter int          RESULT_DEPTH  = 4,
  parameter logic [39:0] RANGE_CYCLES  = 40'h20_0000_0000,
  parameter int          SETTLE_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [767:0] work_data,
  output logic [767:0] core_header,
  output logic         core_load,
  input  logic [32:0]  core_nonce_in,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic         busy,
  output logic         need_work,
  output logic         overflow
`ifdef MINER_SCHED_STATS_EN
  ,
  output logic [15:0]  stat_found,
  output logic [15:0]  stat_dropped
`endif
);

  localparam int PTR_W = $clog2(RESULT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SETTLE    = 3'd2;
  localparam logic [2:0] ST_MINING    = 3'd3;
  localparam logic [2:0] ST_EXHAUSTED = 3'd4;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [39:0]      RANGE_LAST  = RANGE_CYCLES - 40'd1;
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(RESULT_DEPTH);

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [7:0]       settle_cnt;
  logic [39:0]      range_cnt;
  logic [32:0]      nonce_q;
  logic [31:0]      last_nonce;
  logic             last_valid;
  logic [31:0]      mem [RESULT_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic transfer;
  logic capture_en;
  logic new_result;
  logic full;
  logic pop;
  logic do_push;
  logic drop;

  assign work_ready = rst_n && (state == ST_IDLE || state == ST_MINING || state == ST_EXHAUSTED);
  assign transfer   = work_valid && work_ready;
  assign core_load  = (state == ST_LOAD);
  assign busy       = (state == ST_LOAD) || (state == ST_SETTLE) || (state == ST_MINING);
  assign need_work  = (state == ST_IDLE) || (state == ST_EXHAUSTED);

  // A result is new only if the flag is set and it differs from the last captured nonce
  assign capture_en = (state == ST_MINING) || (state == ST_EXHAUSTED);
  assign new_result = capture_en && nonce_q[32] && (!last_valid || (nonce_q[31:0] != last_nonce));

  assign full      = (count == FULL_COUNT);
  assign res_valid = (count != '0);
  assign pop       = res_valid && res_ready;
  assign do_push   = new_result && (!full || pop);
  assign drop      = new_result && full && !pop;
  assign res_nonce = res_valid ? mem[rd_ptr] : 32'd0;

  // Next-state selection; a new work transfer wins over range exhaustion
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_EXHAUSTED: if (transfer) next_state = ST_LOAD;
      ST_LOAD:               next_state = ST_SETTLE;
      ST_SETTLE:             if (settle_cnt == SETTLE_LAST) next_state = ST_MINING;
      ST_MINING: begin
        if (transfer)                     next_state = ST_LOAD;
        else if (range_cnt == RANGE_LAST) next_state = ST_EXHAUSTED;
      end
      default:               next_state = ST_IDLE;
    endcase
  end

  // State register, header latch and settle/range counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      core_header <= '0;
      settle_cnt  <= '0;
      range_cnt   <= '0;
    end else begin
      state <= next_state;
      if (transfer) core_header <= work_data;
      case (state)
        ST_LOAD: begin
          settle_cnt <= '0;
          range_cnt  <= '0;
        end
        ST_SETTLE: settle_cnt <= settle_cnt + 8'd1;
        ST_MINING: range_cnt  <= range_cnt + 40'd1;
        default: ;
      endcase
    end
  end

  // Input register on the core nonce bus and duplicate-suppression tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonce_q    <= '0;
      last_nonce <= '0;
      last_valid <= 1'b0;
    end else begin
      nonce_q <= core_nonce_in;
      if (state == ST_LOAD) begin
        last_nonce <= '0;
        last_valid <= 1'b0;
      end else if (new_result) begin
        last_nonce <= nonce_q[31:0];
        last_valid <= 1'b1;
      end
    end
  end

  // Result storage; contents are only visible through res_nonce while count is nonzero
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= nonce_q[31:0];
  end

  // Result FIFO pointers, occupancy and sticky drop indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef MINER_SCHED_STATS_EN
  // Saturating counters of detected and dropped results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_found   <= '0;
      stat_dropped <= '0;
    end else begin
      if (new_result && stat_found != 16'hFFFF)  stat_found   <= stat_found + 16'd1;
      if (drop && stat_dropped != 16'hFFFF)      stat_dropped <= stat_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_miner_work_scheduler.sv
// tb/tb_miner_work_scheduler.sv - directed scoreboard bench for miner_work_scheduler
module tb_miner_work_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [767:0] work_data = '0;
  logic [767:0] core_header;
  logic         core_load;
  logic [32:0]  core_nonce_in = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [31:0]  res_nonce;
  logic         busy;
  logic         need_work;
  logic         overflow;
`ifdef MINER_SCHED_STATS_EN
  logic [15:0]  stat_found;
  logic [15:0]  stat_dropped;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];
  int exp_found = 0;
  int exp_drop  = 0;

  miner_work_scheduler #(
    .RESULT_DEPTH (4),
    .RANGE_CYCLES (40'd100),
    .SETTLE_CYCLES(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .work_valid   (work_valid),
    .work_ready   (work_ready),
    .work_data    (work_data),
    .core_header  (core_header),
    .core_load    (core_load),
    .core_nonce_in(core_nonce_in),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_nonce    (res_nonce),
    .busy         (busy),
    .need_work    (need_work),
    .overflow     (overflow)
`ifdef MINER_SCHED_STATS_EN
    ,
    .stat_found   (stat_found),
    .stat_dropped (stat_dropped)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [767:0] rand_work();
    logic [767:0] r;
    for (int i = 0; i < 24; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Called at a negedge; returns at the first negedge after the transfer edge
  task automatic drive_work(input string tag, input logic [767:0] d);
    work_data  = d;
    work_valid = 1'b1;
    chk(tag, work_ready, 1'b1);
    @(negedge clk);
    work_valid = 1'b0;
  endtask

  // Called at a negedge; compares the FIFO head with the scoreboard and pops it
  task automatic pop_one(input string tag);
    logic [31:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_nonce"}, res_nonce, e);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic chk_stats(input string tag);
`ifdef MINER_SCHED_STATS_EN
    chk({tag, "_found"}, stat_found, 16'(exp_found));
    chk({tag, "_dropped"}, stat_dropped, 16'(exp_drop));
`else
    chk({tag, "_ovf_only"}, overflow, (exp_drop > 0) ? 1'b1 : 1'b0);
`endif
  endtask

  initial begin
    logic [767:0] wd;
    logic [31:0]  n;
    int loads;
    int k;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_work_ready", work_ready, 1'b0);
    chk("rst_core_load", core_load, 1'b0);
    chk("rst_header", core_header, '0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_nonce", res_nonce, 32'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_need_work", need_work, 1'b1);
    chk_stats("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // First work unit: load pulse, header capture, settle timing
    wd = rand_work();
    wd[383:352] = 32'h1D000000;
    drive_work("w1_ready", wd);
    loads = core_load ? 1 : 0;
    chk("w1_load_c1", core_load, 1'b1);
    chk("w1_header", core_header, wd);
    chk("w1_busy", busy, 1'b1);
    chk("w1_need_work", need_work, 1'b0);
    chk("w1_load_ready", work_ready, 1'b0);
    work_data = ~wd;
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      if (core_load) loads++;
      if (c == 4) chk("w1_settle_ready", work_ready, 1'b0);
      if (c == 5) chk("w1_mining_ready", work_ready, 1'b1);
    end
    chk("w1_load_pulses", 32'(loads), 32'd1);
    chk("w1_header_held", core_header, wd);
    chk("w1_mining_busy", busy, 1'b1);

    // Single golden nonce held for 10 cycles: one push only
    core_nonce_in = {1'b1, 32'h1D0000A5};
    sb.push_back(32'h1D0000A5);
    exp_found++;
    @(negedge clk);
    chk("g1_lat1", res_valid, 1'b0);
    @(negedge clk);
    chk("g1_lat2", res_valid, 1'b1);
    repeat (8) @(negedge clk);
    pop_one("g1_pop");
    chk("g1_empty", res_valid, 1'b0);
    core_nonce_in = '0;
    @(negedge clk);

    // Five distinct results into a 4-deep FIFO with no pops
    for (int i = 0; i < 5; i++) begin
      n = 32'h1D000100 + 32'(i);
      core_nonce_in = {1'b1, n};
      exp_found++;
      if (i < 4) sb.push_back(n);
      else exp_drop++;
      @(negedge clk);
    end
    core_nonce_in = '0;
    chk("ovf_before_drop", overflow, 1'b0);
    @(negedge clk);
    chk("ovf_after_drop", overflow, 1'b1);
    chk("ovf_res_valid", res_valid, 1'b1);
    chk_stats("ovf");

    // Full FIFO: push and pop in the same cycle, nothing dropped
    core_nonce_in = {1'b1, 32'h1D000200};
    exp_found++;
    @(negedge clk);
    pop_one("fp_pop");
    sb.push_back(32'h1D000200);
    core_nonce_in = '0;
    @(negedge clk);
    chk("fp_overflow", overflow, 1'b1);
    chk_stats("fp");
    k = sb.size();
    for (int i = 0; i < k; i++) pop_one("fp_drain");
    chk("fp_empty", res_valid, 1'b0);

    // Range exhaustion after 100 mining cycles
    drive_work("ex_ready", rand_work());
    k = 1;
    while (need_work !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("ex_cycles", 32'(k), 32'd105);
    chk("ex_work_ready", work_ready, 1'b1);
    chk("ex_busy", busy, 1'b0);
    wd = rand_work();
    drive_work("ex_reload_ready", wd);
    chk("ex_reload_load", core_load, 1'b1);
    chk("ex_reload_busy", busy, 1'b1);
    chk("ex_reload_header", core_header, wd);
    repeat (4) @(negedge clk);

    // Queue results, preempt, then reset in the middle of settle
    core_nonce_in = {1'b1, 32'hCAFE0001};
    sb.push_back(32'hCAFE0001);
    @(negedge clk);
    core_nonce_in = {1'b1, 32'hCAFE0002};
    sb.push_back(32'hCAFE0002);
    @(negedge clk);
    core_nonce_in = '0;
    repeat (2) @(negedge clk);
    chk("pre_valid", res_valid, 1'b1);
    drive_work("pre_ready", rand_work());
    chk("pre_load", core_load, 1'b1);
    chk("pre_kept_valid", res_valid, 1'b1);
    chk("pre_kept_head", res_nonce, sb[0]);
    @(negedge clk);
    chk("pre_settle_busy", busy, 1'b1);
    chk("pre_settle_ready", work_ready, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    exp_found = 0;
    exp_drop  = 0;
    #1;
    chk("mr_res_valid", res_valid, 1'b0);
    chk("mr_core_load", core_load, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_need_work", need_work, 1'b1);
    chk("mr_work_ready", work_ready, 1'b0);
    chk("mr_overflow", overflow, 1'b0);
    chk("mr_header", core_header, '0);
    chk_stats("mr");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_need_work", need_work, 1'b1);
    chk("post_work_ready", work_ready, 1'b1);
    chk("post_res_valid", res_valid, 1'b0);
    chk("post_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/miner_work_scheduler.md
Name: miner_work_scheduler

Overview:
- Controller that sequences the SHA-256 miner core.
- Accepts 768-bit work units from the host via valid/ready, drives the core's header bus and load strobe, and watches the core's 33-bit flagged nonce output.
- Captures each new golden nonce into a small result FIFO.
- Raises need_work when the nonce range is exhausted; accepts new work at any time (preemption).

Parameters:
- RESULT_DEPTH, 4: result FIFO entries; power of two, 2..16.
- RANGE_CYCLES, 40'h20_0000_0000: mining cycles before the range counts as exhausted (2^32 nonces x 32 cycles at LOOP_LOG2=5).
- SETTLE_CYCLES, 3: cycles after core_load before core_nonce_in is trusted.

Ports:
- clk  in  1  miner clock
- rst_n  in  1  asynchronous active-low reset
- work_valid  in  1  host offers work
- work_ready  out  1  scheduler accepts work this cycle
- work_data  in  768  {data[511:0], midstate[255:0]}
- core_header  out  768  registered copy of the accepted work_data, held stable
- core_load  out  1  one-cycle pulse to the core's load_done
- core_nonce_in  in  33  core nonce_out; bit 32 = found flag, [31:0] = golden nonce
- res_valid  out  1  FIFO not empty
- res_ready  in  1  host pops the result
- res_nonce  out  32  FIFO head
- busy  out  1  state is LOAD, SETTLE or MINING
- need_work  out  1  state is IDLE or EXHAUSTED
- overflow  out  1  sticky: a result was dropped

Behaviour:
- Reset (async assert, sync release): state IDLE; core_header=0; core_load=0; FIFO empty; res_valid=0; res_nonce=0; overflow=0; busy=0; need_work=1; work_ready=0 during reset.
- work_ready=1 in IDLE, MINING and EXHAUSTED; 0 in LOAD and SETTLE. A transfer occurs when work_valid & work_ready.
- FSM states: IDLE, LOAD, SETTLE, MINING, EXHAUSTED.
  - IDLE/EXHAUSTED/MINING + transfer: latch work_data into core_header on that edge, go to LOAD.
  - LOAD: core_load=1 for exactly this one cycle. Clear last_nonce to 0, last_valid=0, range counter=0. Next state SETTLE.
  - SETTLE: count SETTLE_CYCLES cycles (the core clears its found flag and reloads its nonce), then MINING. core_nonce_in is ignored here.
  - MINING: range counter increments each cycle. When the counter reaches RANGE_CYCLES-1, go to EXHAUSTED on the next edge. A transfer has priority over exhaustion in the same cycle.
  - EXHAUSTED: core_header is held; the core keeps running but results are still captured.
- Golden capture (MINING or EXHAUSTED only): a new result exists when core_nonce_in[32]=1 and (!last_valid or core_nonce_in[31:0]!=last_nonce).
  - On a new result: push core_nonce_in[31:0], set last_nonce to that value, set last_valid=1.
  - A repeated value is never pushed twice.
- FIFO: first-word fall-through; res_nonce is valid whenever res_valid=1; pop on res_valid & res_ready.
  - Push while full without a same-cycle pop: drop the value, set overflow=1 (cleared only by rst_n).
  - Push and pop in the same cycle while full: both happen, no drop, count unchanged.
  - Push while empty: res_valid=1 on the next cycle.
  - Pointers wrap modulo RESULT_DEPTH; count width is clog2(RESULT_DEPTH)+1.
- Preemption does not flush the FIFO; results from the old work remain poppable.
- rst_n asserted mid-operation: immediate return to reset values; in-flight FIFO contents are lost.
- Latency:
  - Transfer edge to core_load high: 1 cycle.
  - Transfer to MINING: 2+SETTLE_CYCLES cycles.
  - Found flag/nonce change to res_valid on an empty FIFO: 2 cycles (input register, then push).

Optional Feature:
- Macro: MINER_SCHED_STATS_EN.
- Defined: adds output ports stat_found[15:0] and stat_dropped[15:0].
  - stat_found counts every detected new result; stat_dropped counts every dropped result.
  - Both saturate at 16'hFFFF and reset to 0 only on rst_n.
- Undefined: ports and counters are absent; only the sticky overflow indicates drops.

Test Plan:
- Reset, then one work unit with work_data[383:352]=32'h1D000000 -> core_load pulses once on cycle 1 after the transfer; core_header equals work_data; busy=1; need_work=0; MINING reached after 5 cycles.
- In MINING, drive core_nonce_in={1'b1,32'h1D0000A5} and hold it for 10 cycles -> exactly one push; res_nonce=32'h1D0000A5; res_valid=1; a pop empties the FIFO.
- With res_ready=0, present 5 distinct golden nonces (RESULT_DEPTH=4) -> first 4 kept in order; 5th dropped; overflow=1; with MINER_SCHED_STATS_EN, stat_found=5 and stat_dropped=1.
- FIFO full, res_ready=1 in the same cycle as a new golden nonce -> no drop; count stays 4; overflow unchanged.
- RANGE_CYCLES overridden to 40'd100 with no results -> EXHAUSTED after 100 MINING cycles; need_work=1; work_ready=1; a new transfer re-enters LOAD.
- Preempt in MINING with queued results, then assert rst_n low mid-SETTLE -> queued results survive the preempt; after reset, FIFO empty, state IDLE, core_load=0.
